hc_loopback_engine: RTL

Parametrised loopback engine for the hardcloud buffer layer: on `start` it reads `len` consecutive cache lines from a source buffer, optionally complements each line, and writes it to the same offset of a destination buffer. It keeps up to `MAX_OUTSTANDING` reads in flight, accepts out-of-order read responses, and raises `finish` once every write is acknowledged. It sits between the accelerator top-level control (`start`/`finish`) and the buffer read/write request channels.

---
 rtl/hc_loopback_engine.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/hc_loopback_engine.sv
// hc_loopback_engine: copies len cache lines from SRC_BUFFER to the same
// offsets of DST_BUFFER, optionally complementing each line. Up to
// MAX_OUTSTANDING lines are in flight or buffered; read responses may return
// in any order and are written out in arrival order. finish is raised once
// every write has been acknowledged.
module hc_loopback_engine #(
  parameter int DATA_WIDTH      = 512,
  parameter int OFFSET_WIDTH    = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int SRC_BUFFER      = 1,
  parameter int DST_BUFFER      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [OFFSET_WIDTH-1:0] len,
  input  logic                    invert,
  output logic                    finish,
  output logic                    rd_req_valid,
  output logic [7:0]              rd_req_buffer,
  output logic [OFFSET_WIDTH-1:0] rd_req_offset,
  input  logic                    rd_almost_full,
  input  logic                    rd_rsp_valid,
  input  logic [OFFSET_WIDTH-1:0] rd_rsp_offset,
  input  logic [DATA_WIDTH-1:0]   rd_rsp_data,
  output logic                    wr_req_valid,
  output logic [7:0]              wr_req_buffer,
  output logic [OFFSET_WIDTH-1:0] wr_req_offset,
  output logic [DATA_WIDTH-1:0]   wr_req_data,
  input  logic                    wr_almost_full,
  input  logic                    wr_rsp_valid
);

  localparam int PW   = $clog2(MAX_OUTSTANDING);
  localparam int CW   = PW + 1;
  localparam int CNTW = OFFSET_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } t_state;

  t_state r_state;
  t_state w_state_next;

  logic [CNTW-1:0] r_len;
  logic            r_invert;
  logic [CNTW-1:0] r_rd_issued;
  logic [CNTW-1:0] r_wr_issued;
  logic [CNTW-1:0] r_wr_acked;
  logic [CW-1:0]   r_credits;
  logic            r_rd_af;
  logic            r_wr_af;

  logic [PW-1:0]           r_fifo_wr_ptr;
  logic [PW-1:0]           r_fifo_rd_ptr;
  logic [CW-1:0]           r_fifo_count;
  logic [OFFSET_WIDTH-1:0] r_fifo_off  [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0]   r_fifo_data [MAX_OUTSTANDING];

  logic            w_rd_issue;
  logic            w_wr_issue;
  logic            w_push;
  logic            w_finish_next;
  logic [CNTW-1:0] w_acked_next;

  assign rd_req_buffer = 8'(SRC_BUFFER);
  assign wr_req_buffer = 8'(DST_BUFFER);

  // Ack count including an ack sampled this edge, so finish rises on that edge
  assign w_acked_next = r_wr_acked + CNTW'(wr_rsp_valid);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_next = (len == '0) ? DONE : RUN;
      RUN:  if (w_acked_next == r_len) w_state_next = DONE;
      DONE: if (!start) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Issue, push and finish decisions for the coming edge
  always_comb begin
    w_rd_issue    = 1'b0;
    w_wr_issue    = 1'b0;
    w_push        = 1'b0;
    w_finish_next = (w_state_next == DONE);
    if (r_state == RUN) begin
      w_rd_issue = (r_rd_issued < r_len) && (r_credits < CW'(MAX_OUTSTANDING)) && !r_rd_af;
      w_wr_issue = (r_fifo_count != '0) && (r_wr_issued < r_len) && !r_wr_af;
      w_push     = rd_rsp_valid;
    end
  end

  // Run parameters, progress counters, credits and registered back-pressure
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len       <= '0;
      r_invert    <= 1'b0;
      r_rd_issued <= '0;
      r_wr_issued <= '0;
      r_wr_acked  <= '0;
      r_credits   <= '0;
      r_rd_af     <= 1'b0;
      r_wr_af     <= 1'b0;
    end else begin
      r_rd_af <= rd_almost_full;
      r_wr_af <= wr_almost_full;
      if (r_state == IDLE && start) begin
        r_len       <= {1'b0, len};
        r_invert    <= invert;
        r_rd_issued <= '0;
        r_wr_issued <= '0;
        r_wr_acked  <= '0;
      end else begin
        if (w_rd_issue) r_rd_issued <= r_rd_issued + CNTW'(1);
        if (w_wr_issue) r_wr_issued <= r_wr_issued + CNTW'(1);
        if (r_state == RUN && wr_rsp_valid) r_wr_acked <= w_acked_next;
      end
      if (w_rd_issue && !w_wr_issue)      r_credits <= r_credits + CW'(1);
      else if (!w_rd_issue && w_wr_issue) r_credits <= r_credits - CW'(1);
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fifo_wr_ptr <= '0;
      r_fifo_rd_ptr <= '0;
      r_fifo_count  <= '0;
    end else begin
      if (w_push)     r_fifo_wr_ptr <= r_fifo_wr_ptr + PW'(1);
      if (w_wr_issue) r_fifo_rd_ptr <= r_fifo_rd_ptr + PW'(1);
      if (w_push && !w_wr_issue)      r_fifo_count <= r_fifo_count + CW'(1);
      else if (!w_push && w_wr_issue) r_fifo_count <= r_fifo_count - CW'(1);
    end
  end

  // Response FIFO storage; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_off[r_fifo_wr_ptr]  <= rd_rsp_offset;
      r_fifo_data[r_fifo_wr_ptr] <= rd_rsp_data;
    end
  end

  // Registered request and finish outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      finish        <= 1'b0;
      rd_req_valid  <= 1'b0;
      rd_req_offset <= '0;
      wr_req_valid  <= 1'b0;
      wr_req_offset <= '0;
      wr_req_data   <= '0;
    end else begin
      finish       <= w_finish_next;
      rd_req_valid <= w_rd_issue;
      wr_req_valid <= w_wr_issue;
      if (w_rd_issue) rd_req_offset <= r_rd_issued[OFFSET_WIDTH-1:0];
      if (w_wr_issue) begin
        wr_req_offset <= r_fifo_off[r_fifo_rd_ptr];
        wr_req_data   <= r_invert ? ~r_fifo_data[r_fifo_rd_ptr] : r_fifo_data[r_fifo_rd_ptr];
      end
    end
  end

endmodule
